// File: rtl/spi_rx_fifo.sv
// SPI receive byte FIFO: 3-flop strobe sync, push 3 clk edges after spi_done is first sampled high,
// first-word-fall-through read. The consumer backpressures with rd_ready; bytes arriving while full are dropped and flagged.
module spi_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spi_done,
  input  logic [7:0]    spi_dout,
  input  logic          rd_ready,
  input  logic          clr_ovf,
  output logic          rd_valid,
  output logic [7:0]    rd_data,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic          s1, s2, s3;
  logic          cap, full, pop, push, drop;
  logic [AW-1:0] wptr, rptr;
  logic [7:0]    mem [DEPTH];

  // Chain resets high so a strobe already high at reset release is not seen as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= spi_done;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign cap      = s2 & ~s3;
  assign full     = (count == FULL_CNT);
  assign rd_valid = (count != '0);
  assign pop      = rd_valid & rd_ready;
  assign push     = cap & (~full | pop);
  assign drop     = cap & full & ~pop;
  assign rd_data  = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= spi_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Directed bench for spi_rx_fifo with immediate-assertion checks.
module tb_spi_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_done;
  logic [7:0] spi_dout;
  logic       rd_ready;
  logic       clr_ovf;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [3:0] count;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] seen[$];
  bit         mon = 1'b0;
  int         max_cnt = 0;

  spi_rx_fifo #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .rst(rst), .spi_done(spi_done), .spi_dout(spi_dout),
    .rd_ready(rd_ready), .clr_ovf(clr_ovf), .rd_valid(rd_valid),
    .rd_data(rd_data), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (mon) begin
      if (rd_valid) seen.push_back(rd_data);
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame: strobe high 3 edges, optional pop/clear during the capture cycle, low 2 edges.
  task automatic send(input logic [7:0] b, input bit pop_cap, input bit clr_cap);
    spi_dout = b;
    spi_done = 1'b1;
    tick();
    tick();
    if (pop_cap) rd_ready = 1'b1;
    if (clr_cap) clr_ovf = 1'b1;
    tick();
    if (pop_cap) rd_ready = 1'b0;
    clr_ovf  = 1'b0;
    spi_done = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    logic [7:0] exp_q[$];
    rst = 1'b1; spi_done = 1'b1; spi_dout = 8'h00; rd_ready = 1'b0; clr_ovf = 1'b0;
    tick();
    tick();
    chk("reset_valid", 32'(rd_valid), 32'h0);
    chk("reset_count", 32'(count), 32'h0);
    chk("reset_ovf", 32'(overflow), 32'h0);

    // Strobe held high through reset release must not capture.
    rst = 1'b0;
    repeat (5) tick();
    chk("held_high_count", 32'(count), 32'h0);
    spi_done = 1'b0;
    repeat (3) tick();

    // Single byte with latency check.
    spi_dout = 8'hA5;
    spi_done = 1'b1;
    tick();
    chk("lat_edge1_valid", 32'(rd_valid), 32'h0);
    tick();
    chk("lat_edge2_valid", 32'(rd_valid), 32'h0);
    tick();
    chk("lat_edge3_valid", 32'(rd_valid), 32'h1);
    chk("single_data", 32'(rd_data), 32'hA5);
    chk("single_count", 32'(count), 32'h1);
    spi_done = 1'b0;
    tick();
    tick();
    rd_ready = 1'b1;
    tick();
    chk("single_pop_valid", 32'(rd_valid), 32'h0);
    chk("single_pop_count", 32'(count), 32'h0);
    tick();
    chk("empty_ready_count", 32'(count), 32'h0);
    rd_ready = 1'b0;

    // Fill and overflow.
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0, 1'b0);
    chk("fill8_count", 32'(count), 32'h8);
    chk("fill8_ovf", 32'(overflow), 32'h0);
    send(8'h09, 1'b0, 1'b0);
    chk("fill9_count", 32'(count), 32'h8);
    chk("fill9_ovf", 32'(overflow), 32'h1);
    rd_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain1_valid", 32'(rd_valid), 32'h1);
      chk("drain1_data", 32'(rd_data), 32'(i));
      tick();
    end
    chk("drain1_empty", 32'(rd_valid), 32'h0);
    rd_ready = 1'b0;
    chk("ovf_sticky", 32'(overflow), 32'h1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_clear_later", 32'(overflow), 32'h0);

    // Full with simultaneous pop.
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b0, 1'b0);
    chk("fullpop_pre_count", 32'(count), 32'h8);
    send(8'h55, 1'b1, 1'b0);
    chk("fullpop_count", 32'(count), 32'h8);
    chk("fullpop_ovf", 32'(overflow), 32'h0);
    exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h55};
    rd_ready = 1'b1;
    foreach (exp_q[i]) begin
      chk("drain2_data", 32'(rd_data), 32'(exp_q[i]));
      tick();
    end
    chk("drain2_empty", 32'(rd_valid), 32'h0);
    rd_ready = 1'b0;

    // Drop and clear in the same cycle: set wins.
    for (int i = 0; i < 8; i++) send(8'h20 + 8'(i), 1'b0, 1'b0);
    send(8'h99, 1'b0, 1'b1);
    chk("clr_drop_ovf", 32'(overflow), 32'h1);
    chk("clr_drop_count", 32'(count), 32'h8);

    // Asynchronous reset with count = 5.
    rd_ready = 1'b1;
    repeat (3) tick();
    rd_ready = 1'b0;
    chk("pre_rst_count", 32'(count), 32'h5);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_count", 32'(count), 32'h0);
    chk("async_rst_valid", 32'(rd_valid), 32'h0);
    chk("async_rst_ovf", 32'(overflow), 32'h0);
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // Wrap-around with continuous read.
    rd_ready = 1'b1;
    mon = 1'b1;
    for (int i = 0; i < 20; i++) send(8'h80 + 8'(i), 1'b0, 1'b0);
    tick();
    mon = 1'b0;
    rd_ready = 1'b0;
    chk("wrap_n", 32'(seen.size()), 32'd20);
    chk("wrap_maxcnt", 32'(max_cnt), 32'd1);
    for (int i = 0; i < 20; i++) begin
      if (i < seen.size()) chk("wrap_data", 32'(seen[i]), 32'(8'h80 + 8'(i)));
    end
    chk("wrap_final_count", 32'(count), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_rx_fifo.md
# spi_rx_fifo

Receive-side byte buffer that sits directly downstream of the SPI slave. It synchronises the slave's frame-complete strobe into the system clock domain and captures each received byte into a DEPTH-entry FIFO. Bytes are presented to the consumer over a first-word-fall-through valid/ready interface, and bytes arriving while the FIFO is full are reported through a sticky overflow flag.

## Interface
- DEPTH, default 8: FIFO entries; power of two, at least 2.
- AW, default 3: pointer width, equal to log2(DEPTH).

- clk  in  1: system clock; all state on the rising edge.
- rst  in  1: asynchronous, active-high reset.
- spi_done  in  1: slave frame-complete level (sclk domain, asynchronous to clk).
- spi_dout  in  8: slave received byte. Stable from the spi_done rise until the next frame starts (at least 8 sclk periods).
- rd_ready  in  1: consumer accepts rd_data.
- clr_ovf  in  1: clear sticky overflow.
- rd_valid  out  1: FIFO non-empty; rd_data is valid.
- rd_data  out  8: head-of-FIFO byte.
- count  out  AW+1: current occupancy, 0..DEPTH.
- overflow  out  1: sticky; a byte was dropped because the FIFO was full.

## Operation
- **Sync chain:** s1 <- spi_done, s2 <- s1, s3 <- s2. All three flops reset to 1.
- **Capture pulse:** cap = s2 & ~s3, exactly one clk cycle per spi_done rising edge.
  - Because the chain resets to 1, a spi_done held high through reset release is not captured. A low then high transition is required.
- **Push:** when cap = 1 and (count < DEPTH or pop), write spi_dout to mem[wptr] and increment wptr, wrapping modulo DEPTH.
- **Pop:** pop = rd_valid & rd_ready. Increment rptr, wrapping modulo DEPTH.
- **Count update:**
  - count + 1 on push only.
  - count − 1 on pop only.
  - Unchanged on push and pop together, or on neither.
- **Outputs:** rd_valid = (count != 0). rd_data = mem[rptr], combinational from memory and registered rptr (fall-through).
- **Drop:** when cap = 1, count == DEPTH and no pop, the byte is discarded. Set overflow = 1 and leave pointers and count unchanged.
- **Overflow clear:** clr_ovf = 1 clears overflow on the next edge. If a drop occurs in the same cycle, set wins and overflow stays 1.
- **Reset values:**
  - count = 0, wptr = rptr = 0, overflow = 0.
  - rd_valid = 0. rd_data is don't-care while rd_valid = 0.
  - Memory contents are not reset.

## Timing
- **Latency:** spi_done first sampled high at edge n; cap is high between edges n+1 and n+2; the byte is written and rd_valid rises at edge n+2. That is 3 clk edges, plus up to 1 cycle of sampling uncertainty.
- **Capture sampling:** spi_dout is sampled at the push edge, n+2. The upstream stability guarantee covers this edge whenever the sclk period × 8 exceeds 3 clk periods.
- **Back-to-back frames:** spi_done must be low for at least 2 clk cycles between rises. Shorter gaps may merge two rises into one capture; this is not a required case.
- **Full and pop together:** pop and push in the same cycle at count == DEPTH is accepted. Count stays DEPTH and nothing is dropped.
- **Empty:** a push at count == 0 makes rd_valid 1 after the edge. rd_ready while empty has no effect.
- **Wrap-around:** pointers roll from DEPTH−1 to 0 with no gap.
- **Reset mid-operation:** asserting rst immediately empties the FIFO and clears overflow, regardless of pending cap or pop. An in-flight synchronised edge is lost.

## Test plan
- **Single byte:** after reset, pulse spi_done with spi_dout = 8'hA5 and rd_ready = 0 -> rd_valid rises 3 edges after the first high sample, rd_data = 8'hA5, count = 1. Raise rd_ready -> rd_valid = 0 next edge, count = 0.
- **Fill and overflow:** 9 frames (8'h01..8'h09) with rd_ready = 0 -> count = 8 and overflow = 1 after the 9th. Draining yields 8'h01..8'h08 in order; 8'h09 is absent.
- **Full with simultaneous pop:** FIFO full, rd_ready = 1 held in the cycle cap fires with 8'h55 -> count stays 8, overflow stays 0, and 8'h55 is read last.
- **Wrap-around:** 20 frames with rd_ready = 1 continuously -> all 20 bytes read in order, count never exceeds 1, pointers wrap twice.
- **Overflow clear:**
  - clr_ovf asserted in the same cycle as a drop -> overflow stays 1.
  - clr_ovf asserted in a later cycle with no drop -> overflow = 0.
- **Reset behaviour:**
  - spi_done held high across rst release -> no capture, count = 0.
  - Assert rst with count = 5 -> count = 0, rd_valid = 0, overflow = 0 immediately, asynchronously.
